// File: rtl/alu_fpu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared alu_fpu; one transaction in flight.
// Define FPU_MULTICYCLE_EN to give float operations FP_LAT cycles of execution instead of one.
module alu_fpu_arbiter #(
    parameter int FP_LAT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] req_a,
    input  logic [127:0] req_b,
    input  logic [7:0]   req_op,
    input  logic [1:0]   req_is_float,
    output logic [63:0]  alu_a,
    output logic [63:0]  alu_b,
    output logic [3:0]   alu_op,
    output logic         alu_is_float,
    input  logic [63:0]  alu_result,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [63:0]  resp_data,
    output logic         busy
);

    localparam bit MULTICYCLE =
`ifdef FPU_MULTICYCLE_EN
        1'b1;
`else
        1'b0;
`endif
    localparam logic [3:0] FLOAT_LAT_M1 = MULTICYCLE ? 4'(FP_LAT - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_reg;
    logic        owner_reg;
    logic        last_grant_reg;
    logic [3:0]  count_reg;
    logic [63:0] alu_a_reg;
    logic [63:0] alu_b_reg;
    logic [3:0]  alu_op_reg;
    logic        alu_is_float_reg;
    logic [1:0]  resp_valid_reg;
    logic [63:0] resp_data_reg;
    logic        busy_reg;

    logic [63:0] a_arr [2];
    logic [63:0] b_arr [2];
    logic [3:0]  op_arr [2];
    logic        f_arr [2];
    logic        grant;
    logic        accept;
    logic [3:0]  lat_m1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign a_arr[gi]  = req_a[64*gi +: 64];
            assign b_arr[gi]  = req_b[64*gi +: 64];
            assign op_arr[gi] = req_op[4*gi +: 4];
            assign f_arr[gi]  = req_is_float[gi];
            // Ready is held low while reset is asserted so nothing appears accepted.
            assign req_ready[gi] = reset_n && (state_reg == IDLE) && req_valid[gi]
                                   && (grant == 1'(gi));
        end
    endgenerate

    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_reg;
            default: grant = 1'b0;
        endcase
    end

    assign accept = |req_ready;
    assign lat_m1 = f_arr[grant] ? FLOAT_LAT_M1 : 4'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            owner_reg        <= 1'b0;
            last_grant_reg   <= 1'b1;
            count_reg        <= 4'd0;
            alu_a_reg        <= 64'd0;
            alu_b_reg        <= 64'd0;
            alu_op_reg       <= 4'd0;
            alu_is_float_reg <= 1'b0;
            resp_valid_reg   <= 2'b00;
            resp_data_reg    <= 64'd0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        alu_a_reg        <= a_arr[grant];
                        alu_b_reg        <= b_arr[grant];
                        alu_op_reg       <= op_arr[grant];
                        alu_is_float_reg <= f_arr[grant];
                        owner_reg        <= grant;
                        count_reg        <= lat_m1;
                        busy_reg         <= 1'b1;
                        state_reg        <= EXEC;
                    end
                end
                EXEC: begin
                    if (count_reg == 4'd0) begin
                        resp_data_reg  <= alu_result;
                        resp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
                        state_reg      <= RESP;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                RESP: begin
                    // Operands return to zero together with the move back to IDLE.
                    if (resp_ready[owner_reg]) begin
                        resp_valid_reg   <= 2'b00;
                        last_grant_reg   <= owner_reg;
                        alu_a_reg        <= 64'd0;
                        alu_b_reg        <= 64'd0;
                        alu_op_reg       <= 4'd0;
                        alu_is_float_reg <= 1'b0;
                        busy_reg         <= 1'b0;
                        state_reg        <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign alu_a        = alu_a_reg;
    assign alu_b        = alu_b_reg;
    assign alu_op       = alu_op_reg;
    assign alu_is_float = alu_is_float_reg;
    assign resp_valid   = resp_valid_reg;
    assign resp_data    = resp_data_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_alu_fpu_arbiter.sv
// Randomized bench for alu_fpu_arbiter with a transaction-level reference model and a
// behavioural alu_fpu model driving alu_result.
module tb_alu_fpu_arbiter;

    localparam int FP_LAT = 4;
`ifdef FPU_MULTICYCLE_EN
    localparam int FLAT = FP_LAT;
`else
    localparam int FLAT = 1;
`endif
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [7:0]   req_op = '0;
    logic [1:0]   req_is_float = '0;
    logic [63:0]  alu_a;
    logic [63:0]  alu_b;
    logic [3:0]   alu_op;
    logic         alu_is_float;
    logic [63:0]  alu_result;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready = 2'b00;
    logic [63:0]  resp_data;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester-side view of the operands and the model's round-robin pointer.
    logic [63:0] ta [2];
    logic [63:0] tb_ [2];
    logic [3:0]  top [2];
    logic        tf [2];
    logic        model_last = 1'b1;
    logic [63:0] got;

    alu_fpu_arbiter #(.FP_LAT(FP_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_is_float(req_is_float),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_float(alu_is_float),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [3:0] op, input logic f);
        real ra, rb;
        if (f) begin
            ra = $bitstoreal(a);
            rb = $bitstoreal(b);
            case (op)
                OP_ADD:  return $realtobits(ra + rb);
                OP_SUB:  return $realtobits(ra - rb);
                OP_MUL:  return $realtobits(ra * rb);
                default: return a;
            endcase
        end
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op, alu_is_float);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pack_reqs();
        req_a        = {ta[1], ta[0]};
        req_b        = {tb_[1], tb_[0]};
        req_op       = {top[1], top[0]};
        req_is_float = {tf[1], tf[0]};
    endtask

    function automatic logic [63:0] rand_operand(input logic f);
        if (f) return $realtobits(real'($urandom_range(0, 50)));
        return {$urandom, $urandom};
    endfunction

    task automatic randomize_req(input int i);
        tf[i]  = 1'($urandom_range(0, 1));
        top[i] = 4'($urandom_range(0, 5));
        ta[i]  = rand_operand(tf[i]);
        tb_[i] = rand_operand(tf[i]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check_eq({tag, "_resp_data"}, resp_data, 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_alu"}, alu_a | alu_b | {59'd0, alu_op, alu_is_float}, 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        model_last = 1'b1;
    endtask

    // hold < 0: resp_ready held high throughout; otherwise owner ready withheld for hold cycles.
    task automatic run_txn(input logic [1:0] mask, input int hold, output logic [63:0] data);
        logic        eg;
        logic [1:0]  eoh;
        int          lat;
        logic [63:0] ed;
        bit          seen;
        int          bcnt;
        @(posedge clk);
        #1;
        pack_reqs();
        req_valid  = mask;
        resp_ready = (hold < 0) ? 2'b11 : 2'b00;
        eg  = (mask == 2'b11) ? ~model_last : mask[1];
        eoh = eg ? 2'b10 : 2'b01;
        lat = tf[eg] ? FLAT : 1;
        ed  = alu_model(ta[eg], tb_[eg], top[eg], tf[eg]);
        @(negedge clk);
        check_eq("grant", 64'(req_ready), 64'(eoh));
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("idle_alu", alu_a | alu_b | {59'd0, alu_op, alu_is_float}, 64'd0);
        @(posedge clk);
        #1;
        // Inputs after acceptance must not matter.
        ta[eg]  = {$urandom, $urandom};
        tb_[eg] = {$urandom, $urandom};
        top[eg] = 4'($urandom_range(0, 15));
        pack_reqs();
        req_valid[eg] = 1'($urandom_range(0, 1));
        seen = 0;
        bcnt = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            check_eq("busy_no_grant", 64'(req_ready), 64'd0);
            if (busy) bcnt++;
            if (resp_valid != 2'b00) begin
                seen = 1;
                check_eq("latency", 64'(k), 64'(1 + lat));
            end else begin
                @(posedge clk);
                #1;
                req_valid[~eg] = 1'($urandom_range(0, 1));
            end
        end
        check_eq("resp_valid", 64'(resp_valid), 64'(eoh));
        check_eq("resp_data", resp_data, ed);
        data = resp_data;
        if (hold >= 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                resp_ready = ~eoh;
                req_valid  = 2'b11;
                @(negedge clk);
                check_eq("hold_valid", 64'(resp_valid), 64'(eoh));
                check_eq("hold_data", resp_data, ed);
                check_eq("hold_no_grant", 64'(req_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            resp_ready = eoh;
            req_valid  = 2'b11;
            @(negedge clk);
            check_eq("hs_no_grant", 64'(req_ready), 64'd0);
            check_eq("hs_busy", 64'(busy), 64'd1);
        end else begin
            check_eq("busy_cycles", 64'(bcnt), 64'(1 + lat));
        end
        @(posedge clk);
        #1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        model_last = eg;
        @(negedge clk);
        check_eq("after_valid", 64'(resp_valid), 64'd0);
        check_eq("after_busy", 64'(busy), 64'd0);
        $display("txn mask=%b owner=%0d float=%0b lat=%0d hold=%0d data=%h",
                 mask, eg, tf[eg], lat, hold, data);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) randomize_req(i);
        pack_reqs();
        #2 reset_n = 1'b0;
        req_valid = 2'b11;
        #1 check_outputs_zero("reset");
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Integer ADD on requester 0 with resp_ready held high.
        ta[0] = 64'd10; tb_[0] = 64'd20; top[0] = OP_ADD; tf[0] = 1'b0;
        run_txn(2'b01, -1, got);
        check_eq("add_10_20", got, 64'd30);

        // First tie after reset goes to requester 0, then round-robin to requester 1.
        do_reset();
        ta[0] = 64'd30; tb_[0] = 64'd10; top[0] = OP_SUB; tf[0] = 1'b0;
        ta[1] = 64'd1;  tb_[1] = 64'd2;  top[1] = OP_ADD; tf[1] = 1'b0;
        run_txn(2'b11, 1, got);
        check_eq("tie_first_sub", got, 64'd20);
        run_txn(2'b11, 2, got);
        check_eq("tie_second_add", got, 64'd3);

        // Float MUL on requester 1.
        ta[1] = $realtobits(3.0); tb_[1] = $realtobits(2.0); top[1] = OP_MUL; tf[1] = 1'b1;
        run_txn(2'b10, -1, got);
        check_eq("fmul_3_2", got, $realtobits(6.0));

        // Owner withholds resp_ready for five cycles while the other side is ready.
        randomize_req(0);
        run_txn(2'b01, 5, got);

        // Reset in the middle of a float operation.
        @(posedge clk);
        #1;
        ta[1] = $realtobits(3.0); tb_[1] = $realtobits(2.0); top[1] = OP_MUL; tf[1] = 1'b1;
        pack_reqs();
        req_valid = 2'b10;
        @(posedge clk);
        #1;
        check_eq("exec_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        req_valid = 2'b00;
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_last = 1'b1;
        for (int k = 0; k < 2 * FP_LAT + 4; k++) begin
            @(negedge clk);
            check_eq("discarded_resp", 64'(resp_valid), 64'd0);
        end
        $display("txn reset-discard checked");

        for (int t = 0; t < 40; t++) begin
            randomize_req(0);
            randomize_req(1);
            run_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 4)) - 1, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
